// File: rtl/load_store_unit_if.sv
// Request/response handshake between the execute stage and the load/store unit.
// Latency: none; this is a pure signal bundle.
// Backpressure: req_ready low means req_valid is ignored and the request must be held.
//
// Ports (signals):
//   req_valid/req_ready  request handshake, execute stage -> LSU
//   req_write/req_wide   store/load select, 16-bit/8-bit select
//   req_addr/req_wdata   byte address of the low byte, store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata           load result, held until the next load completes
interface load_store_unit_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_wide;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              resp_valid;
    logic [15:0]       resp_rdata;

    modport master (
        output req_valid, req_write, req_wide, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_wide, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: splits 8/16-bit requests into little-endian byte accesses on a byte memory.
// Latency: resp_valid two cycles after accept (narrow), three cycles (wide).
// Backpressure: req_ready only in IDLE; one request per 3 (narrow) or 4 (wide) cycles.
//
// Ports:
//   clk, rst_n        clock shared with the data memory, async active-low reset
//   bus (slave)       request/response handshake, see load_store_unit_if
//   memRead/memWrite  byte read/write strobes, only active in BYTE0/BYTE1
//   address           byte address (zero when no access in progress)
//   writeData         byte store data (zero when no access in progress)
//   readData          combinational byte read data from the memory
//   access_count      completed requests, saturating at 16'hFFFF
module load_store_unit #(
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    load_store_unit_if.slave    bus,
    output logic                memRead,
    output logic                memWrite,
    output logic [ADDR_W-1:0]   address,
    output logic [7:0]          writeData,
    input  logic [7:0]          readData,
    output logic [15:0]         access_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE0 = 2'd1,
        BYTE1 = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic              wide_q, wide_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    // Low byte of a wide load, parked until the high byte arrives so the
    // visible result only changes when the whole load completes.
    logic [7:0]        rlo_q, rlo_d;
    logic [15:0]       rdata_q, rdata_d;
    logic [15:0]       count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            wide_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 16'h0000;
            rlo_q   <= 8'h00;
            rdata_q <= 16'h0000;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            wide_q  <= wide_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rlo_q   <= rlo_d;
            rdata_q <= rdata_d;
            count_q <= count_d;
        end
    end

    // Memory strobes are decoded from state only, so the async reset forcing
    // state to IDLE drops them in the same cycle.
    always_comb begin
        state_d        = state_q;
        write_d        = write_q;
        wide_d         = wide_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rlo_d          = rlo_q;
        rdata_d        = rdata_q;
        count_d        = count_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        memRead        = 1'b0;
        memWrite       = 1'b0;
        address        = '0;
        writeData      = 8'h00;

        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    wide_d  = bus.req_wide;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    state_d = BYTE0;
                end
            end

            BYTE0: begin
                address = addr_q;
                if (write_q) begin
                    memWrite  = 1'b1;
                    writeData = wdata_q[7:0];
                end else begin
                    memRead = 1'b1;
                    if (wide_q) begin
                        rlo_d = readData;
                    end else begin
                        rdata_d = {8'h00, readData};
                    end
                end
                state_d = wide_q ? BYTE1 : RESP;
            end

            BYTE1: begin
                // High byte address wraps modulo 2^ADDR_W.
                address = addr_q + ADDR_W'(1);
                if (write_q) begin
                    memWrite  = 1'b1;
                    writeData = wdata_q[15:8];
                end else begin
                    memRead = 1'b1;
                    rdata_d = {readData, rlo_q};
                end
                state_d = RESP;
            end

            RESP: begin
                bus.resp_valid = 1'b1;
                if (count_q != 16'hFFFF) begin
                    count_d = count_q + 16'h0001;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.resp_rdata = rdata_q;
    assign access_count   = count_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-array memory and a
// behavioural model of memory contents, load results and the request counter.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memRead, memWrite;
    logic [7:0]  address, writeData, readData;
    logic [15:0] access_count;

    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(8)) bus ();

    load_store_unit #(.ADDR_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .address      (address),
        .writeData    (writeData),
        .readData     (readData),
        .access_count (access_count)
    );

    // Data memory: combinational read, write on the rising edge.
    logic [7:0] mem [256];
    assign readData = mem[address];
    always @(posedge clk) if (memWrite === 1'b1) mem[address] <= writeData;

    // Reference model state.
    logic [7:0]  ref_mem [256];
    logic [15:0] exp_rdata;
    logic [15:0] exp_count;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    // Strobes must be mutually exclusive in every cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            tot_cnt++;
            if (!(memRead === 1'b0 || memWrite === 1'b0))
                $display("FAIL strobe_excl: memRead=%b memWrite=%b required not both 1", memRead, memWrite);
            else
                pass_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [51:0] obs_now();
        return {bus.req_ready, bus.resp_valid, memRead, memWrite,
                address, writeData, bus.resp_rdata, access_count};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    task automatic drive_junk(input bit v);
        bus.req_valid = v;
        bus.req_write = 1'($urandom);
        bus.req_wide  = 1'($urandom);
        bus.req_addr  = 8'($urandom);
        bus.req_wdata = 16'($urandom);
    endtask

    // Issue one request from IDLE and check every cycle until RESP.
    // Returns at the RESP-cycle falling edge.
    task automatic run_req(input bit w, input bit wd, input logic [7:0] a,
                           input logic [15:0] d, input bit hold, input bit no_wait,
                           input string tag);
        logic [7:0]  a1;
        logic [15:0] prev_rd, new_rd;
        logic [51:0] obs, exp;
        a1      = a + 8'd1;
        prev_rd = exp_rdata;
        if (w) begin
            ref_mem[a] = d[7:0];
            if (wd) ref_mem[a1] = d[15:8];
            new_rd = prev_rd;
        end else begin
            new_rd = wd ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
        end

        if (!no_wait) @(negedge clk);
        obs = obs_now();
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, prev_rd, exp_count};
        tot_cnt++;
        if (obs !== exp) $display("FAIL %s idle: got %h required %h", tag, obs, exp);
        else pass_cnt++;

        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_wide  = wd;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(negedge clk);
        drive_junk(hold);
        obs = obs_now();
        exp = {1'b0, 1'b0, ~w, w, a, (w ? d[7:0] : 8'h00), prev_rd, exp_count};
        tot_cnt++;
        if (obs !== exp) $display("FAIL %s byte0: got %h required %h", tag, obs, exp);
        else pass_cnt++;

        if (wd) begin
            @(negedge clk);
            drive_junk(hold);
            obs = obs_now();
            exp = {1'b0, 1'b0, ~w, w, a1, (w ? d[15:8] : 8'h00), prev_rd, exp_count};
            tot_cnt++;
            if (obs !== exp) $display("FAIL %s byte1: got %h required %h", tag, obs, exp);
            else pass_cnt++;
        end

        @(negedge clk);
        drive_junk(hold);
        obs = obs_now();
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, new_rd, exp_count};
        tot_cnt++;
        if (obs !== exp) $display("FAIL %s resp: got %h required %h", tag, obs, exp);
        else pass_cnt++;

        exp_rdata = new_rd;
        exp_count = sat_inc(exp_count);
    endtask

    task automatic test_reset();
        logic [51:0] obs, exp;
        #1;
        obs = obs_now();
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 16'h0000};
        tot_cnt++;
        if (obs !== exp) $display("FAIL reset_t0: got %h required %h", obs, exp);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        obs = obs_now();
        tot_cnt++;
        if (obs !== exp) $display("FAIL reset_held: got %h required %h", obs, exp);
        else pass_cnt++;
        // Release just before a rising edge; that very edge must accept.
        rst_n = 1'b1;
        run_req(1'b1, 1'b0, 8'h05, 16'h0077, 1'b0, 1'b1, "first_after_reset");
    endtask

    task automatic test_directed();
        logic [31:0] got;
        run_req(1'b1, 1'b0, 8'h10, 16'h00A5, 1'b0, 1'b0, "narrow_store");
        run_req(1'b0, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, "narrow_load");
        run_req(1'b1, 1'b1, 8'h20, 16'hBEEF, 1'b0, 1'b0, "wide_store");
        run_req(1'b0, 1'b1, 8'h20, 16'h0000, 1'b0, 1'b0, "wide_load");
        run_req(1'b1, 1'b1, 8'hFF, 16'h1234, 1'b0, 1'b0, "wrap_store");
        run_req(1'b0, 1'b1, 8'hFF, 16'h0000, 1'b0, 1'b0, "wrap_load");
        run_req(1'b1, 1'b0, 8'h10, 16'hFF5A, 1'b0, 1'b0, "narrow_store_hi_ignored");
        run_req(1'b0, 1'b1, 8'h10, 16'h0000, 1'b0, 1'b0, "wide_load_mixed");
        @(negedge clk);
        got = {mem[8'h21], mem[8'h20], mem[8'h00], mem[8'hFF]};
        tot_cnt++;
        if (got !== 32'hBEEF_1234)
            $display("FAIL mem_bytes: got %h required %h", got, 32'hBEEF_1234);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            run_req(1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom),
                    1'b1, 1'b0, "b2b");
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            run_req(1'($urandom), 1'($urandom), 8'($urandom_range(0, 255)),
                    16'($urandom), 1'($urandom), 1'b0, "rand");
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_abort();
        logic [51:0] obs, exp;
        logic [7:0]  old41;
        logic [15:0] got;
        old41 = ref_mem[8'h41];
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_wide  = 1'b1;
        bus.req_addr  = 8'h40;
        bus.req_wdata = 16'hCAFE;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        obs = {36'h0, memWrite, address, writeData, 7'h0};
        exp = {36'h0, 1'b1, 8'h41, 8'hCA, 7'h0};
        tot_cnt++;
        if (obs !== exp) $display("FAIL abort_byte1: got %h required %h", obs, exp);
        else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        obs = obs_now();
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 16'h0000};
        tot_cnt++;
        if (obs !== exp) $display("FAIL abort_async: got %h required %h", obs, exp);
        else pass_cnt++;
        @(negedge clk);
        obs = obs_now();
        tot_cnt++;
        if (obs !== exp) $display("FAIL abort_held: got %h required %h", obs, exp);
        else pass_cnt++;
        got = {mem[8'h41], mem[8'h40]};
        tot_cnt++;
        if (got !== {old41, 8'hFE}) $display("FAIL abort_mem: got %h required %h", got, {old41, 8'hFE});
        else pass_cnt++;
        ref_mem[8'h40] = 8'hFE;
        exp_rdata = 16'h0000;
        exp_count = 16'h0000;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tot_cnt++;
            if (bus.resp_valid !== 1'b0) $display("FAIL abort_no_resp: got %b required 0", bus.resp_valid);
            else pass_cnt++;
        end
        run_req(1'b0, 1'b1, 8'h40, 16'h0000, 1'b0, 1'b0, "load_after_abort");
    endtask

    task automatic test_counter();
        @(negedge clk);
        // Preload the counter close to saturation instead of issuing 65k requests.
        force dut.count_q = 16'hFFFD;
        @(negedge clk);
        @(negedge clk);
        release dut.count_q;
        exp_count = 16'hFFFD;
        for (int i = 0; i < 4; i++) begin
            run_req(1'b0, 1'b0, 8'($urandom), 16'h0000, 1'b0, 1'b0, "count_sat");
        end
        @(negedge clk);
        tot_cnt++;
        if (access_count !== 16'hFFFF) $display("FAIL count_final: got %h required ffff", access_count);
        else pass_cnt++;
    endtask

    task automatic test_mem_image();
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        tot_cnt++;
        if (bad != 0) $display("FAIL mem_image: %0d bytes differ, required 0", bad);
        else pass_cnt++;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_wide  = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        exp_rdata = 16'h0000;
        exp_count = 16'h0000;

        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_abort();
        test_counter();
        test_mem_image();

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
